// File: rtl/inst_rom_resp.sv
// Instruction-fetch responder: word-addressed ROM/RAM with a fixed-latency read
// pipeline feeding a credit-controlled response FIFO, plus a program-load port.
module inst_rom_resp #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    parameter int AW     = 10,
    parameter int LAT    = 2,
    parameter int FIFO_D = 4,
    parameter logic [INST_W-1:0] NOP = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PC_W-1:0]   req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [PC_W-1:0]   resp_pc,
    output logic [INST_W-1:0] resp_inst,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [INST_W-1:0] ld_data
);

    localparam int PW = $clog2(FIFO_D);
    localparam int CW = $clog2(FIFO_D + LAT + 1) + 1;

    logic [INST_W-1:0] mem [2**AW];

    logic [LAT-1:0]    st_valid_reg;
    logic [PC_W-1:0]   st_pc_reg   [LAT];
    logic              st_err_reg  [LAT];
    logic [INST_W-1:0] st_data_reg [LAT];

    logic [PC_W-1:0]   fifo_pc   [FIFO_D];
    logic [INST_W-1:0] fifo_inst [FIFO_D];
    logic              fifo_err  [FIFO_D];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg, count_next;
    logic [CW-1:0]     inflight;

    logic accept, fault, push, pop;

    assign fault  = (req_pc[1:0] != 2'b00) | (req_pc[PC_W-1:AW+2] != '0);
    assign accept = req_valid & req_ready;
    assign push   = st_valid_reg[LAT-1];
    assign pop    = resp_valid & resp_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(st_valid_reg[i]);
        end
    end

    // Credits count everything already committed (in the pipe or buffered),
    // so a push can never land on a full FIFO.
    assign req_ready = rst && ((inflight + count_reg) < CW'(FIFO_D));

    // Non-blocking read and write in one block: a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (accept) begin
            st_data_reg[0] <= mem[req_pc[AW+1:2]];
        end
        for (int i = 1; i < LAT; i++) begin
            st_data_reg[i] <= st_data_reg[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_valid_reg <= '0;
        end else begin
            st_valid_reg[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                st_valid_reg[i] <= st_valid_reg[i-1];
            end
        end
        if (accept) begin
            st_pc_reg[0]  <= req_pc;
            st_err_reg[0] <= fault;
        end
        for (int i = 1; i < LAT; i++) begin
            st_pc_reg[i]  <= st_pc_reg[i-1];
            st_err_reg[i] <= st_err_reg[i-1];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr_reg]   <= st_pc_reg[LAT-1];
                fifo_inst[wr_ptr_reg] <= st_err_reg[LAT-1] ? NOP : st_data_reg[LAT-1];
                fifo_err[wr_ptr_reg]  <= st_err_reg[LAT-1];
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Head fields are gated so an empty or resetting buffer shows all zeros.
    assign resp_valid = (count_reg != '0);
    assign resp_pc    = resp_valid ? fifo_pc[rd_ptr_reg]   : '0;
    assign resp_inst  = resp_valid ? fifo_inst[rd_ptr_reg] : '0;
    assign resp_err   = resp_valid ? fifo_err[rd_ptr_reg]  : 1'b0;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: load, streaming, backpressure, faults,
// load/fetch collision and reset with requests in flight.
module tb_inst_rom_resp;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int AW     = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [PC_W-1:0]   req_pc;
    logic              resp_valid;
    logic              resp_ready;
    logic [PC_W-1:0]   resp_pc;
    logic [INST_W-1:0] resp_inst;
    logic              resp_err;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [INST_W-1:0] ld_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int acc;

    always #5 clk = ~clk;

    inst_rom_resp dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_pc    (resp_pc),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input string tag, input logic [63:0] pc,
                               input logic [31:0] inst, input logic err);
        $display("[TB] %s: valid=%0b pc=%0h inst=%08h err=%0b", tag, resp_valid, resp_pc, resp_inst, resp_err);
        check({tag, ".valid"}, 64'(resp_valid), 64'(1'b1));
        check({tag, ".pc"},    resp_pc, pc);
        check({tag, ".inst"},  64'(resp_inst), 64'(inst));
        check({tag, ".err"},   64'(resp_err), 64'(err));
    endtask

    // Holds req_valid high for ncyc cycles, counting accepts; pc advances by 4 per accept.
    task automatic burst(input int ncyc, output int n_acc);
        n_acc     = 0;
        req_valid = 1'b1;
        req_pc    = 64'h0;
        for (int i = 0; i < ncyc; i++) begin
            logic took;
            took = req_ready;
            tick();
            if (took) begin
                n_acc++;
                req_pc = req_pc + 64'd4;
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_pc     = '0;
        resp_ready = 1'b0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;

        // Reset
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.req_ready", 64'(req_ready), 64'(1'b0));
            check("rst.resp_valid", 64'(resp_valid), 64'(1'b0));
        end
        check("rst.resp_pc", resp_pc, 64'h0);
        check("rst.resp_inst", 64'(resp_inst), 64'h0);
        rst = 1'b1;
        #1;
        check("post_rst.req_ready", 64'(req_ready), 64'(1'b1));

        // Program load: words 0..3 and word 5
        for (int i = 0; i < 6; i++) begin
            ld_en   = (i != 4);
            ld_addr = AW'(i);
            ld_data = (i == 5) ? 32'h55555555 : {8{4'(i + 1)}};
            tick();
        end
        ld_en = 1'b0;

        // Streaming: four back-to-back fetches, first response LAT+1 cycles later
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_pc     = 64'd0;  tick();
        req_pc     = 64'd4;  tick();
        req_pc     = 64'd8;  tick();
        expect_resp("stream0", 64'd0, 32'h11111111, 1'b0);
        req_pc     = 64'd12; tick();
        expect_resp("stream1", 64'd4, 32'h22222222, 1'b0);
        req_valid  = 1'b0;   tick();
        expect_resp("stream2", 64'd8, 32'h33333333, 1'b0);
        tick();
        expect_resp("stream3", 64'd12, 32'h44444444, 1'b0);
        tick();
        check("stream.empty", 64'(resp_valid), 64'(1'b0));

        // Backpressure: credits limit accepts to the buffer depth
        resp_ready = 1'b0;
        burst(8, acc);
        check("bp.accepts", 64'(acc), 64'd4);
        check("bp.req_ready", 64'(req_ready), 64'(1'b0));
        expect_resp("bp.head", 64'd0, 32'h11111111, 1'b0);
        tick();
        expect_resp("bp.hold", 64'd0, 32'h11111111, 1'b0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("bp.no_credit_on_pop", 64'(req_ready), 64'(1'b0));
        tick();
        check("bp.credit_back", 64'(req_ready), 64'(1'b1));
        expect_resp("drain1", 64'd4, 32'h22222222, 1'b0);
        tick();
        expect_resp("drain2", 64'd8, 32'h33333333, 1'b0);
        tick();
        expect_resp("drain3", 64'd12, 32'h44444444, 1'b0);
        tick();
        check("drain.empty", 64'(resp_valid), 64'(1'b0));

        // Faults: misaligned and out-of-range
        req_valid = 1'b1;
        req_pc    = 64'h2;    tick();
        req_pc    = 64'h1000; tick();
        req_valid = 1'b0;     tick();
        expect_resp("fault.mis", 64'h2, 32'h00000013, 1'b1);
        tick();
        expect_resp("fault.oor", 64'h1000, 32'h00000013, 1'b1);
        tick();
        check("fault.empty", 64'(resp_valid), 64'(1'b0));

        // Load and fetch of the same word in one cycle
        ld_en     = 1'b1;
        ld_addr   = AW'(5);
        ld_data   = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_pc    = 64'd20; tick();
        ld_en     = 1'b0;   tick();
        req_valid = 1'b0;   tick();
        expect_resp("coll.old", 64'd20, 32'h55555555, 1'b0);
        tick();
        expect_resp("coll.new", 64'd20, 32'hDEADBEEF, 1'b0);
        tick();

        // Reset while two requests are in the pipe
        req_valid = 1'b1;
        req_pc    = 64'd8;  tick();
        req_pc    = 64'd12; tick();
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        check("midrst.req_ready", 64'(req_ready), 64'(1'b0));
        tick();
        rst = 1'b1;
        #1;
        check("midrst.credit", 64'(req_ready), 64'(1'b1));
        for (int i = 0; i < 5; i++) begin
            check("midrst.no_resp", 64'(resp_valid), 64'(1'b0));
            tick();
        end
        resp_ready = 1'b0;
        burst(8, acc);
        req_valid = 1'b0;
        check("midrst.accepts", 64'(acc), 64'd4);
        expect_resp("midrst.head", 64'd0, 32'h11111111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
- Responder end of the instruction-fetch interface: accepts PC fetch requests from the fetch stage (pc_reg/if_id side) and returns the 32-bit instruction word at that PC.
- Word-addressed synchronous instruction memory, fixed-latency read pipeline, credit-based output buffer and a word-write port for program loading.
- Sits between the PC generator and the IF/ID register.

Parameters:
- PC_W, 64, width of fetch address and returned PC
- INST_W, 32, instruction word width
- AW, 10, log2 of memory depth in words (1024 words = 4 KiB)
- LAT, 2, read pipeline latency in cycles from request accept to FIFO write; legal range 1..4
- FIFO_D, 4, output buffer depth in entries; power of two, at least 2
- NOP, 32'h00000013, word returned on a faulted fetch

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept a request
- req_pc  in  PC_W  fetch address (byte address)
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts the response
- resp_pc  out  PC_W  PC of the returned word
- resp_inst  out  INST_W  instruction word
- resp_err  out  1  fetch fault (misaligned or out of range)
- ld_en  in  1  program-load write enable
- ld_addr  in  AW  word address for the load
- ld_data  in  INST_W  word to write

Behaviour:
- Reset: rst sampled low at a clk edge clears the FIFO pointers and count, all pipeline valid bits and the credit count.
  - req_ready=0 while rst=0; resp_valid=0, resp_pc=0, resp_inst=0, resp_err=0.
  - Memory contents are not cleared.
  - Requests already in flight when reset is asserted mid-operation are discarded; no response ever appears for them.
- Accept: a request is accepted on a clk edge where req_valid=1 and req_ready=1. req_pc is captured that cycle.
- Credit rule: req_ready=1 iff rst=1 and (inflight + fifo_count) < FIFO_D, where inflight is the number of valid pipeline stages.
  - req_ready is registered-free combinational from counters only; it never depends on req_valid.
  - A response popped in the same cycle does not free a credit until the next cycle.
- Fault check at accept:
  - err_mis = req_pc[1:0] != 0.
  - err_oor = req_pc[PC_W-1:AW+2] != 0.
  - err = err_mis | err_oor.
  - On a fault, memory data is ignored and NOP is delivered with resp_err=1.
- Read pipeline:
  - Memory is read with word index req_pc[AW+1:2] at accept.
  - Data, PC and err travel LAT stages and are written into the FIFO exactly LAT cycles after accept.
  - Back-to-back accepts give back-to-back FIFO writes (throughput 1 per cycle).
- Write/read collision: ld_en write to the same word read in the same cycle returns the OLD word; the write is visible to reads accepted from the next cycle onward. Loads are accepted at any time, including during fetch.
- Output:
  - resp_* present the FIFO head; resp_valid = fifo_count != 0.
  - Pop on resp_valid & resp_ready.
  - Simultaneous FIFO push and pop keeps the count unchanged and is legal at full and at empty. At empty, a pushed word appears on resp_valid the cycle after the push, not combinationally.
  - Order is strict FIFO; responses are never reordered or dropped.
- Stability: while resp_valid=1 and resp_ready=0, resp_pc/resp_inst/resp_err hold stable.
- Wrap-around: FIFO pointers wrap modulo FIFO_D. The credit rule guarantees no overflow, so the FIFO never sees a push when full.
- Latency: an accept at cycle N with resp_ready=1 gives resp_valid at cycle N+LAT+1.

Test Plan:
- Reset/load:
  - Stimulus: hold rst=0 for 3 cycles, then ld words 0..3 = 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444.
  - Required: req_ready=0 and resp_valid=0 during reset, req_ready=1 after.
- Streaming:
  - Stimulus: rst=1, resp_ready=1, pc=0,4,8,12 on consecutive cycles.
  - Required: the four words above appear in order on 4 consecutive cycles starting LAT+1 cycles after the first accept, resp_err=0.
- Backpressure:
  - Stimulus: resp_ready=0, req_valid=1 continuously.
  - Required: exactly FIFO_D=4 accepts, then req_ready=0; outputs hold the pc=0 entry stable.
  - Release resp_ready: remaining 3 entries drain in order, and req_ready returns high the cycle after the first pop.
- Faults:
  - Stimulus: pc=64'h2 and pc=64'h1000 (AW=10).
  - Required: each returns resp_inst=32'h00000013, resp_err=1, resp_pc echoing the request.
- Collision:
  - Stimulus: ld_en to word 5 with 32'hDEADBEEF in the same cycle as a fetch of pc=20, then fetch pc=20 again.
  - Required: the first fetch returns the old word, the second returns 32'hDEADBEEF.
- Reset mid-flight:
  - Stimulus: accept 2 requests, assert rst=0 for 1 cycle before they reach the FIFO.
  - Required: no response ever appears for them, the count is 0, and full credit (4) is available after reset.
